// File: rtl/bus_dma.sv
// Register-programmed single-channel DMA: copies LEN words from SRC to DST over a
// host bus with one outstanding transaction, raising a level interrupt when done.
module bus_dma #(
    parameter int AddrOffsetBits = 10
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dev_req_i,
    input  logic [31:0] dev_addr_i,
    input  logic        dev_we_i,
    input  logic [3:0]  dev_be_i,
    input  logic [31:0] dev_wdata_i,
    output logic        dev_rvalid_o,
    output logic [31:0] dev_rdata_o,
    output logic        dev_err_o,
    output logic        host_req_o,
    output logic [31:0] host_addr_o,
    output logic        host_we_o,
    output logic [3:0]  host_be_o,
    output logic [31:0] host_wdata_o,
    input  logic        host_gnt_i,
    input  logic        host_rvalid_i,
    input  logic [31:0] host_rdata_i,
    input  logic        host_err_i,
    output logic        irq_o
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] src_r, dst_r, cur_src_r, cur_dst_r, buf_r;
    logic [15:0] len_r, count_r;
    logic        irq_en_r, done_r, err_r;
    logic        dev_rvalid_r, dev_err_r;
    logic [31:0] dev_rdata_r;

    logic [31:0] word_s, rd_data_s;
    logic        acc_err_s, wr_ok_s, busy_s, start_s;
    logic        host_req_s, host_we_s;
    logic [31:0] host_addr_s, host_wdata_s;
    logic [3:0]  host_be_s;
    logic        rd_done_s, step_s, last_s, abort_s;

    // Config-port decode and read mux.
    always_comb begin
        word_s    = 32'(dev_addr_i[AddrOffsetBits-1:2]);
        acc_err_s = (word_s > 32'd4) || (dev_we_i && (dev_be_i != 4'hF));
        wr_ok_s   = dev_req_i && dev_we_i && !acc_err_s;
        busy_s    = (state_r != IDLE);
        start_s   = wr_ok_s && (word_s == 32'd3) && dev_wdata_i[0] && !busy_s;
        case (word_s)
            32'd0:   rd_data_s = src_r;
            32'd1:   rd_data_s = dst_r;
            32'd2:   rd_data_s = {16'h0000, len_r};
            32'd3:   rd_data_s = {30'h0, irq_en_r, 1'b0};
            32'd4:   rd_data_s = {29'h0, err_r, done_r, busy_s};
            default: rd_data_s = 32'h0;
        endcase
    end

    // Transfer FSM next-state and host request outputs (driven from registers only).
    always_comb begin
        state_s      = state_r;
        host_req_s   = 1'b0;
        host_we_s    = 1'b0;
        host_be_s    = 4'h0;
        host_addr_s  = 32'h0;
        host_wdata_s = 32'h0;
        rd_done_s    = 1'b0;
        step_s       = 1'b0;
        last_s       = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_s && (len_r != 16'd0)) begin
                    state_s = RD_REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_REQ: begin
                host_req_s  = 1'b1;
                host_be_s   = 4'hF;
                host_addr_s = cur_src_r;
                if (host_gnt_i) begin
                    state_s = RD_WAIT;
                end else begin
                    state_s = RD_REQ;
                end
            end
            RD_WAIT: begin
                if (host_rvalid_i && host_err_i) begin
                    abort_s = 1'b1;
                    state_s = IDLE;
                end else if (host_rvalid_i) begin
                    rd_done_s = 1'b1;
                    state_s   = WR_REQ;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            WR_REQ: begin
                host_req_s   = 1'b1;
                host_we_s    = 1'b1;
                host_be_s    = 4'hF;
                host_addr_s  = cur_dst_r;
                host_wdata_s = buf_r;
                if (host_gnt_i) begin
                    state_s = WR_WAIT;
                end else begin
                    state_s = WR_REQ;
                end
            end
            WR_WAIT: begin
                if (host_rvalid_i && host_err_i) begin
                    abort_s = 1'b1;
                    state_s = IDLE;
                end else if (host_rvalid_i) begin
                    step_s = 1'b1;
                    if (count_r == 16'd1) begin
                        last_s  = 1'b1;
                        state_s = IDLE;
                    end else begin
                        state_s = RD_REQ;
                    end
                end else begin
                    state_s = WR_WAIT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, config registers, working counters and config response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= IDLE;
            src_r        <= 32'h0;
            dst_r        <= 32'h0;
            len_r        <= 16'h0;
            irq_en_r     <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            cur_src_r    <= 32'h0;
            cur_dst_r    <= 32'h0;
            count_r      <= 16'h0;
            buf_r        <= 32'h0;
            dev_rvalid_r <= 1'b0;
            dev_err_r    <= 1'b0;
            dev_rdata_r  <= 32'h0;
        end else begin
            state_r      <= state_s;
            dev_rvalid_r <= dev_req_i;
            dev_err_r    <= dev_req_i && acc_err_s;
            dev_rdata_r  <= (dev_req_i && !dev_we_i && !acc_err_s) ? rd_data_s : 32'h0;
            if (wr_ok_s && !busy_s) begin
                case (word_s)
                    32'd0:   src_r <= {dev_wdata_i[31:2], 2'b00};
                    32'd1:   dst_r <= {dev_wdata_i[31:2], 2'b00};
                    32'd2:   len_r <= dev_wdata_i[15:0];
                    default: ;
                endcase
            end
            if (wr_ok_s && (word_s == 32'd3)) begin
                irq_en_r <= dev_wdata_i[1];
            end
            // W1C first so that a completion in the same cycle still lands.
            if (wr_ok_s && (word_s == 32'd4)) begin
                if (dev_wdata_i[1]) done_r <= 1'b0;
                if (dev_wdata_i[2]) err_r  <= 1'b0;
            end
            if (start_s) begin
                if (len_r == 16'd0) begin
                    done_r <= 1'b1;
                end else begin
                    cur_src_r <= src_r;
                    cur_dst_r <= dst_r;
                    count_r   <= len_r;
                    done_r    <= 1'b0;
                    err_r     <= 1'b0;
                end
            end
            if (rd_done_s) begin
                buf_r <= host_rdata_i;
            end
            if (step_s) begin
                cur_src_r <= cur_src_r + 32'd4;
                cur_dst_r <= cur_dst_r + 32'd4;
                count_r   <= count_r - 16'd1;
            end
            if (last_s) begin
                done_r <= 1'b1;
            end
            if (abort_s) begin
                done_r <= 1'b1;
                err_r  <= 1'b1;
            end
        end
    end

    assign dev_rvalid_o = dev_rvalid_r;
    assign dev_rdata_o  = dev_rdata_r;
    assign dev_err_o    = dev_err_r;
    assign host_req_o   = host_req_s;
    assign host_addr_o  = host_addr_s;
    assign host_we_o    = host_we_s;
    assign host_be_o    = host_be_s;
    assign host_wdata_o = host_wdata_s;
    assign irq_o        = done_r && irq_en_r;

endmodule

// File: tb/tb_bus_dma.sv
// Scoreboard bench for bus_dma: a memory model grants/answers host traffic and checks it
// against expected copy transactions; a config monitor checks every register response.
module tb_bus_dma;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        dev_req_i = 1'b0, dev_we_i = 1'b0;
    logic [31:0] dev_addr_i = 32'h0, dev_wdata_i = 32'h0;
    logic [3:0]  dev_be_i = 4'h0;
    logic        dev_rvalid_o, dev_err_o;
    logic [31:0] dev_rdata_o;
    logic        host_req_o, host_we_o;
    logic [31:0] host_addr_o, host_wdata_o;
    logic [3:0]  host_be_o;
    logic        host_gnt_i = 1'b0, host_rvalid_i = 1'b0, host_err_i = 1'b0;
    logic [31:0] host_rdata_i = 32'h0;
    logic        irq_o;

    int tests = 0;
    int fails = 0;

    bus_dma #(.AddrOffsetBits(10)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .dev_req_i(dev_req_i), .dev_addr_i(dev_addr_i), .dev_we_i(dev_we_i),
        .dev_be_i(dev_be_i), .dev_wdata_i(dev_wdata_i),
        .dev_rvalid_o(dev_rvalid_o), .dev_rdata_o(dev_rdata_o), .dev_err_o(dev_err_o),
        .host_req_o(host_req_o), .host_addr_o(host_addr_o), .host_we_o(host_we_o),
        .host_be_o(host_be_o), .host_wdata_o(host_wdata_o),
        .host_gnt_i(host_gnt_i), .host_rvalid_i(host_rvalid_i),
        .host_rdata_i(host_rdata_i), .host_err_i(host_err_i),
        .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {logic [31:0] rdata; logic err; logic chk;} dev_exp_t;
    typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata;} host_exp_t;
    dev_exp_t    dev_q[$];
    host_exp_t   host_q[$];
    logic [31:0] mem [bit [31:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Config response monitor.
    always @(negedge clk_i) begin : dev_mon
        dev_exp_t e;
        if (dev_rvalid_o) begin
            if (dev_q.size() == 0) begin
                check("dev_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = dev_q.pop_front();
                check("dev_err", 32'(dev_err_o), 32'(e.err));
                if (e.chk) check("dev_rdata", dev_rdata_o, e.rdata);
            end
        end
    end

    // Host memory model: configurable grant/response delay, error on one address.
    int          gdelay = 0, rdelay = 0, gcnt = 0, rcnt = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic        holding = 1'b0, busy_txn = 1'b0, h_we = 1'b0;
    logic [31:0] h_addr = 32'h0, h_wdata = 32'h0;
    logic [3:0]  h_be = 4'h0;

    always @(negedge clk_i) begin : mem_model
        host_exp_t e;
        if (!rst_ni) begin
            host_gnt_i = 1'b0; host_rvalid_i = 1'b0; host_err_i = 1'b0; host_rdata_i = 32'h0;
            holding = 1'b0; busy_txn = 1'b0;
        end else begin
            host_rvalid_i = 1'b0; host_err_i = 1'b0; host_rdata_i = 32'h0;
            if (host_gnt_i) begin
                host_gnt_i = 1'b0; busy_txn = 1'b1; holding = 1'b0; rcnt = rdelay;
                check("host_be", {28'h0, h_be}, 32'hF);
                if (host_q.size() == 0) begin
                    check("host_unexpected_txn", 32'd1, 32'd0);
                end else begin
                    e = host_q.pop_front();
                    check("host_addr", h_addr, e.addr);
                    check("host_we", 32'(h_we), 32'(e.we));
                    if (e.we) check("host_wdata", h_wdata, e.wdata);
                end
            end
            if (busy_txn) begin
                check("one_outstanding", 32'(host_req_o), 32'd0);
                if (rcnt == 0) begin
                    busy_txn = 1'b0; host_rvalid_i = 1'b1;
                    if (!h_we) begin
                        host_rdata_i = mem.exists(h_addr) ? mem[h_addr] : 32'h0;
                        host_err_i = (h_addr == err_addr);
                    end else begin
                        mem[h_addr] = h_wdata;
                    end
                end else begin
                    rcnt--;
                end
            end else if (host_req_o) begin
                if (!holding) begin
                    holding = 1'b1; gcnt = gdelay;
                    h_addr = host_addr_o; h_we = host_we_o; h_be = host_be_o; h_wdata = host_wdata_o;
                    if (host_q.size() == 0) check("host_unexpected_req", 32'd1, 32'd0);
                end else begin
                    check("hold_addr", host_addr_o, h_addr);
                    check("hold_ctl", {27'h0, host_we_o, host_be_o}, {27'h0, h_we, h_be});
                    check("hold_wdata", host_wdata_o, h_wdata);
                end
                if (gcnt == 0) host_gnt_i = 1'b1;
                else gcnt--;
            end else begin
                check("host_idle_zero", host_addr_o | host_wdata_o | {27'h0, host_we_o, host_be_o}, 32'h0);
            end
        end
    end

    task automatic dev_acc(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input logic exp_err, input logic chk);
        dev_exp_t e;
        e.rdata = exp_rdata; e.err = exp_err; e.chk = chk;
        dev_q.push_back(e);
        dev_req_i = 1'b1; dev_we_i = we; dev_addr_i = addr; dev_be_i = be; dev_wdata_i = wdata;
        @(posedge clk_i); #1;
        dev_req_i = 1'b0; dev_we_i = 1'b0; dev_addr_i = 32'h0; dev_be_i = 4'h0; dev_wdata_i = 32'h0;
        @(negedge clk_i); #1;
        check("dev_latency", 32'(dev_q.size()), 32'd0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        dev_acc(1'b1, addr, 4'hF, data, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        dev_acc(1'b0, addr, 4'hF, 32'h0, exp, 1'b0, 1'b1);
    endtask

    task automatic fill_src(input logic [31:0] s, input int n);
        for (int i = 0; i < n; i++) mem[s + 32'(i) * 32'd4] = $urandom;
    endtask

    // Expected traffic: read word i then write it; an erroring read ends the list.
    task automatic push_xfer(input logic [31:0] s, input logic [31:0] d, input int n, input int err_at);
        host_exp_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = s + 32'(i) * 32'd4; e.we = 1'b0; e.wdata = 32'h0;
            host_q.push_back(e);
            if (i == err_at) begin
                err_addr = e.addr;
                break;
            end
            e.wdata = mem[e.addr]; e.addr = d + 32'(i) * 32'd4; e.we = 1'b1;
            host_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((host_q.size() != 0 || busy_txn || holding) && n < 1000) begin
            @(negedge clk_i); #1;
            n++;
        end
        if (n >= 1000) check("xfer_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clk_i);
        #1;
    endtask

    task automatic outputs_zero(input string name);
        check(name, {host_addr_o | host_wdata_o | dev_rdata_o},  32'h0);
        check({name, "_ctl"}, {25'h0, host_req_o, host_we_o, host_be_o, dev_rvalid_o, dev_err_o, irq_o}, 32'h0);
    endtask

    logic [31:0] s, d;
    int          len, n;
    logic        ien;

    initial begin
        repeat (3) @(negedge clk_i);
        outputs_zero("reset_outputs");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rd(32'h10, 32'h0);
        rd(32'h08, 32'h0);

        // Register access rules: alignment, byte enables, unmapped offsets, start reads 0.
        wr(32'h00, 32'h0000_1237);
        rd(32'h00, 32'h0000_1234);
        dev_acc(1'b1, 32'h00, 4'h3, 32'h0000_5550, 32'h0, 1'b1, 1'b1);
        rd(32'h00, 32'h0000_1234);
        wr(32'h0C, 32'h2);
        rd(32'h0C, 32'h2);
        dev_acc(1'b1, 32'h14, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
        dev_acc(1'b0, 32'h14, 4'hF, 32'h0, 32'h0, 1'b1, 1'b1);
        rd(32'h400, 32'h0000_1234);

        // LEN=0 start: done in the response cycle, no host traffic.
        wr(32'h08, 32'h0);
        wr(32'h0C, 32'h3);
        check("len0_done_1cycle", 32'(irq_o), 32'd1);
        repeat (5) @(negedge clk_i);
        #1;
        rd(32'h10, 32'h2);
        wr(32'h10, 32'h2);
        check("w1c_clears_irq", 32'(irq_o), 32'd0);

        // Zero-wait 4-word copy with fixed addresses.
        gdelay = 0; rdelay = 0;
        s = 32'h0010_0000; d = 32'h0010_0400;
        fill_src(s, 4);
        wr(32'h00, s); wr(32'h04, d); wr(32'h08, 32'd4);
        push_xfer(s, d, 4, -1);
        wr(32'h0C, 32'h3);
        wait_idle();
        rd(32'h10, 32'h2);
        check("copy4_irq", 32'(irq_o), 32'd1);
        rd(32'h00, s);
        wr(32'h10, 32'h2);

        // Single word with grant same-cycle and response one cycle later: done at cycle 5.
        s = 32'h0010_0800; d = 32'h0010_0C00;
        fill_src(s, 1);
        wr(32'h00, s); wr(32'h04, d); wr(32'h08, 32'd1);
        push_xfer(s, d, 1, -1);
        wr(32'h0C, 32'h3);
        n = 1;
        while (!irq_o && n < 20) begin
            @(negedge clk_i); #1;
            n++;
        end
        check("done_latency", 32'(n), 32'd5);
        wait_idle();
        wr(32'h10, 32'h2);

        // Slow bus: outputs must hold while waiting for grant.
        gdelay = 3; rdelay = 2;
        s = 32'h0011_0000; d = 32'h0011_0400;
        fill_src(s, 3);
        wr(32'h00, s); wr(32'h04, d); wr(32'h08, 32'd3);
        push_xfer(s, d, 3, -1);
        wr(32'h0C, 32'h3);
        // Writes while busy: SRC and a second start are ignored, busy reads back.
        wr(32'h00, 32'h0000_5550);
        wr(32'h0C, 32'h3);
        rd(32'h10, 32'h1);
        rd(32'h00, s);
        wait_idle();
        repeat (8) @(negedge clk_i);
        #1;
        rd(32'h10, 32'h2);
        wr(32'h10, 32'h2);

        // Address wrap past 2^32.
        gdelay = 1; rdelay = 0;
        s = 32'hFFFF_FFF8; d = 32'h0012_0000;
        fill_src(s, 3);
        wr(32'h00, s); wr(32'h04, d); wr(32'h08, 32'd3);
        push_xfer(s, d, 3, -1);
        wr(32'h0C, 32'h3);
        wait_idle();
        rd(32'h10, 32'h2);
        wr(32'h10, 32'h2);

        // Read error on the 2nd read aborts after one write.
        gdelay = 0; rdelay = 1;
        s = 32'h0013_0000; d = 32'h0013_0400;
        fill_src(s, 4);
        wr(32'h00, s); wr(32'h04, d); wr(32'h08, 32'd4);
        push_xfer(s, d, 4, 1);
        wr(32'h0C, 32'h3);
        wait_idle();
        err_addr = 32'hFFFF_FFFF;
        rd(32'h10, 32'h6);
        check("err_irq", 32'(irq_o), 32'd1);
        wr(32'h10, 32'h6);
        check("err_w1c_irq", 32'(irq_o), 32'd0);
        rd(32'h10, 32'h0);

        // Randomised copies against the word-copy model.
        for (int t = 0; t < 8; t++) begin
            gdelay = $urandom_range(0, 3); rdelay = $urandom_range(0, 3);
            s = 32'h0001_0000 + 32'($urandom_range(0, 255)) * 32'd4;
            d = 32'h0004_0000 + 32'($urandom_range(0, 255)) * 32'd4;
            len = $urandom_range(1, 6);
            ien = 1'($urandom_range(0, 1));
            fill_src(s, len);
            wr(32'h00, s | 32'($urandom_range(0, 3)));
            rd(32'h00, s);
            wr(32'h04, d); wr(32'h08, 32'(len));
            rd(32'h08, 32'(len));
            push_xfer(s, d, len, -1);
            wr(32'h0C, {30'h0, ien, 1'b1});
            wait_idle();
            check("rand_irq", 32'(irq_o), 32'(ien));
            rd(32'h10, 32'h2);
            wr(32'h10, 32'h2);
        end

        // Reset pulse during a write wait: everything returns to zero, bus goes quiet.
        gdelay = 0; rdelay = 6;
        s = 32'h0014_0000; d = 32'h0014_0400;
        fill_src(s, 3);
        wr(32'h00, s); wr(32'h04, d); wr(32'h08, 32'd3);
        push_xfer(s, d, 3, -1);
        wr(32'h0C, 32'h3);
        n = 0;
        while (!(busy_txn && h_we) && n < 200) begin
            @(negedge clk_i); #1;
            n++;
        end
        check("reach_wr_wait", 32'(busy_txn && h_we), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        outputs_zero("midreset_outputs");
        host_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (10) @(negedge clk_i);
        #1;
        rd(32'h10, 32'h0);
        rd(32'h00, 32'h0);
        rd(32'h0C, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
